// File: rtl/spi_px_bridge.sv
// SPI mode-0 slave to pixel-stream bridge with RX/TX word FIFOs.
// Define SPI_PX_BRIDGE_ERR_EN to build sticky overflow/underflow flags on err_o.
module spi_px_bridge #(
    parameter int PX_BITS   = 24,
    parameter int RX_DEPTH  = 4,
    parameter int TX_DEPTH  = 4,
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               spi_sck_i,
    input  logic               spi_sdi_i,
    input  logic               spi_cs_i,
    output logic               spi_sdo_o,
    output logic [PX_BITS-1:0] rx_px_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    input  logic [PX_BITS-1:0] tx_px_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic               busy_o,
    output logic [1:0]         err_o
);

    localparam int CW  = $clog2(PX_BITS);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int NB  = PX_BITS / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t state, state_nx;

    logic [1:0] sck_s, sdi_s, cs_s;
    logic       sck_d, armed;
    logic       sck, sdi, cs, rise, fall;

    logic load, sample, shift, push_req;

    logic [PX_BITS-1:0] sh_out, sh_in, rx_word;
    logic [CW-1:0]      bit_cnt;

    logic [PX_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]     rx_wr, rx_rd;
    logic [RAW:0]       rx_cnt;
    logic               rx_full, rx_empty, rx_push, rx_pop;

    logic [PX_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]     tx_wr, tx_rd;
    logic [TAW:0]       tx_cnt;
    logic               tx_full, tx_empty, tx_push, tx_pop;

    // Port word <-> wire word; wire is always MSB-first.
    function automatic logic [PX_BITS-1:0] order(input logic [PX_BITS-1:0] v);
        logic [PX_BITS-1:0] r;
        r = v;
        if (BYTE_SWAP) begin
            for (int i = 0; i < NB; i++) begin
                r[8*i +: 8] = v[PX_BITS-8-8*i +: 8];
            end
        end
        return r;
    endfunction

    // armed blocks a frame that was already in progress when reset released
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sck_s <= '0;
            sdi_s <= '0;
            cs_s  <= '0;
            sck_d <= 1'b0;
            armed <= 1'b0;
        end else begin
            sck_s <= {sck_s[0], spi_sck_i};
            sdi_s <= {sdi_s[0], spi_sdi_i};
            cs_s  <= {cs_s[0], spi_cs_i};
            sck_d <= sck_s[1];
            if (cs_s[1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck  = sck_s[1];
    assign sdi  = sdi_s[1];
    assign cs   = cs_s[1];
    assign rise = sck & ~sck_d;
    assign fall = ~sck & sck_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The fall right after a word boundary is skipped: LOAD already
    // presented the new MSB.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        push_req = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!cs && armed) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                load     = 1'b1;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                if (rise) begin
                    sample = 1'b1;
                    if (bit_cnt == CW'(PX_BITS - 1)) begin
                        push_req = 1'b1;
                        state_nx = S_LOAD;
                    end
                end else if (fall && bit_cnt != '0) begin
                    shift = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (cs) begin
            state_nx = S_IDLE;
            load     = 1'b0;
            sample   = 1'b0;
            shift    = 1'b0;
            push_req = 1'b0;
        end
    end

    assign rx_word = {sh_in[PX_BITS-2:0], sdi};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sh_out  <= '0;
            sh_in   <= '0;
            bit_cnt <= '0;
        end else begin
            if (load) begin
                sh_out  <= tx_empty ? '0 : order(tx_mem[tx_rd]);
                bit_cnt <= '0;
            end else if (shift) begin
                sh_out <= {sh_out[PX_BITS-2:0], 1'b0};
            end
            if (sample) begin
                sh_in   <= rx_word;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign busy_o    = (state != S_IDLE);
    assign spi_sdo_o = busy_o & sh_out[PX_BITS-1];

    assign rx_full    = (rx_cnt == (RAW+1)'(RX_DEPTH));
    assign rx_empty   = (rx_cnt == '0);
    assign rx_valid_o = ~rx_empty;
    assign rx_px_o    = rx_mem[rx_rd];
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign rx_push    = push_req & (~rx_full | rx_pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= order(rx_word);
                rx_wr         <= rx_wr + RAW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + RAW'(1);
            end
            if (rx_push && !rx_pop) begin
                rx_cnt <= rx_cnt + (RAW+1)'(1);
            end else if (!rx_push && rx_pop) begin
                rx_cnt <= rx_cnt - (RAW+1)'(1);
            end
        end
    end

    assign tx_full    = (tx_cnt == (TAW+1)'(TX_DEPTH));
    assign tx_empty   = (tx_cnt == '0);
    assign tx_ready_o = ~tx_full;
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign tx_pop     = load & ~tx_empty;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= tx_px_i;
                tx_wr         <= tx_wr + TAW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + TAW'(1);
            end
            if (tx_push && !tx_pop) begin
                tx_cnt <= tx_cnt + (TAW+1)'(1);
            end else if (!tx_push && tx_pop) begin
                tx_cnt <= tx_cnt - (TAW+1)'(1);
            end
        end
    end

`ifdef SPI_PX_BRIDGE_ERR_EN
    logic [1:0] err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err <= 2'b00;
        end else if (state == S_IDLE && state_nx == S_LOAD) begin
            err <= 2'b00;
        end else begin
            if (push_req && !rx_push) begin
                err[0] <= 1'b1;
            end
            if (load && tx_empty) begin
                err[1] <= 1'b1;
            end
        end
    end

    assign err_o = err;
`else
    assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_spi_px_bridge.sv
// Scoreboard bench for spi_px_bridge: random SPI frames and TX pushes
// against a queue-based model of the pixel and wire word streams.
module tb_spi_px_bridge;

    localparam int PXB = 24;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           spi_sck_i, spi_sdi_i, spi_cs_i, spi_sdo_o;
    logic [PXB-1:0] rx_px_o, tx_px_i;
    logic           rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o, busy_o;
    logic [1:0]     err_o;

    int checks = 0;
    int errors = 0;
    bit ready_en = 1'b0;

    logic [PXB-1:0] exp_rx[$];
    logic [PXB-1:0] exp_miso[$];
    logic [PXB-1:0] tx_m[$];
    logic [PXB-1:0] send_q[$];
    logic [PXB-1:0] cur_tx;
    logic           ovf_m, unf_m;
    int             mbits = 0;
    logic [PXB-1:0] mword;

    always #5 clk = ~clk;

    spi_px_bridge #(
        .PX_BITS(PXB), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .BYTE_SWAP(1'b1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .spi_sck_i(spi_sck_i), .spi_sdi_i(spi_sdi_i),
        .spi_cs_i(spi_cs_i), .spi_sdo_o(spi_sdo_o),
        .rx_px_o(rx_px_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_px_i(tx_px_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte list low-to-high, then rebuilt so the lowest byte leads on the wire.
    function automatic logic [PXB-1:0] swap_ref(input logic [PXB-1:0] v);
        byte unsigned b[$];
        logic [PXB-1:0] r;
        r = '0;
        for (int i = 0; i < PXB/8; i++) b.push_back(v[8*i +: 8]);
        foreach (b[i]) r = {r[PXB-9:0], b[i]};
        return r;
    endfunction

    function automatic logic [1:0] err_ref();
`ifdef SPI_PX_BRIDGE_ERR_EN
        return {unf_m, ovf_m};
`else
        return 2'b00;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_load();
        if (tx_m.size() > 0) begin
            cur_tx = tx_m.pop_front();
        end else begin
            cur_tx = '0;
            unf_m  = 1'b1;
        end
    endtask

    task automatic push_tx(input logic [PXB-1:0] w);
        @(negedge clk);
        chk("tx_ready", {31'd0, tx_ready_o}, {31'd0, tx_m.size() < TXD});
        tx_px_i    = w;
        tx_valid_i = 1'b1;
        if (tx_m.size() < TXD) tx_m.push_back(w);
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic shift_word(input logic [PXB-1:0] w, input int nbits);
        exp_miso.push_back(swap_ref(cur_tx));
        for (int i = PXB-1; i >= PXB-nbits; i--) begin
            spi_sdi_i = w[i];
            tick(5);
            spi_sck_i = 1'b1;
            if (i == 0) begin
                if (exp_rx.size() >= RXD) ovf_m = 1'b1;
                else exp_rx.push_back(swap_ref(w));
                model_load();
                if (!ready_en) begin
                    tick(4);
                    chk("rx_latency", {31'd0, rx_valid_o}, 32'd1);
                    tick(1);
                end else begin
                    tick(5);
                end
            end else begin
                tick(5);
            end
            spi_sck_i = 1'b0;
        end
        if (nbits < PXB) void'(exp_miso.pop_back());
    endtask

    // Sends every word in send_q; cut>0 aborts the first word after cut bits.
    task automatic frame(input int cut);
        spi_cs_i = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        model_load();
        tick(6);
        chk("busy_frame", {31'd0, busy_o}, 32'd1);
        if (cut > 0) begin
            shift_word(send_q.pop_front(), cut);
            send_q.delete();
        end
        while (send_q.size() > 0) shift_word(send_q.pop_front(), PXB);
        tick(4);
        spi_cs_i = 1'b1;
        tick(3);
        chk("busy_idle", {31'd0, busy_o}, 32'd0);
        chk("sdo_idle", {31'd0, spi_sdo_o}, 32'd0);
        chk("err_flags", {30'd0, err_o}, {30'd0, err_ref()});
        tick(3);
    endtask

    task automatic drain();
        ready_en = 1'b1;
        for (int i = 0; i < 400 && exp_rx.size() > 0; i++) tick(1);
        chk("rx_drained", exp_rx.size(), 32'd0);
        tick(2);
        chk("rx_empty", {31'd0, rx_valid_o}, 32'd0);
    endtask

    initial begin
        rx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rx_ready_i = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset_i && rx_valid_o && rx_ready_i) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected none", rx_px_o);
            end else begin
                chk("rx_px", rx_px_o, exp_rx.pop_front());
            end
        end
    end

    always @(posedge spi_sck_i or posedge spi_cs_i or posedge reset_i) begin
        if (spi_cs_i || reset_i) begin
            mbits = 0;
        end else begin
            mword = {mword[PXB-2:0], spi_sdo_o};
            mbits++;
            if (mbits == PXB) begin
                mbits = 0;
                if (exp_miso.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got %h expected none", mword);
                end else begin
                    chk("miso_word", mword, exp_miso.pop_front());
                end
            end
        end
    end

    initial begin
        reset_i    = 1'b1;
        spi_sck_i  = 1'b0;
        spi_sdi_i  = 1'b0;
        spi_cs_i   = 1'b1;
        tx_px_i    = '0;
        tx_valid_i = 1'b0;
        ovf_m      = 1'b0;
        unf_m      = 1'b0;
        tick(4);
        reset_i = 1'b0;
        tick(2);
        chk("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_sdo", {31'd0, spi_sdo_o}, 32'd0);
        chk("rst_err", {30'd0, err_o}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);

        // single word, byte order on the RX side
        ready_en = 1'b0;
        push_tx(24'h123456);
        send_q.push_back(24'h112233);
        frame(0);
        chk("rx_head", rx_px_o, 24'h332211);
        drain();

        // two pre-pushed TX words streamed back-to-back
        push_tx(24'hA5C3F0);
        push_tx(24'h0F0F0F);
        send_q.push_back(PXB'($urandom));
        send_q.push_back(PXB'($urandom));
        frame(0);
        drain();

        // RX overflow: RXD+1 words with the core stalled
        ready_en = 1'b0;
        tick(3);
        for (int i = 0; i < RXD + 1; i++) send_q.push_back(PXB'($urandom));
        frame(0);
        chk("rx_full_valid", {31'd0, rx_valid_o}, 32'd1);
        drain();
        push_tx(PXB'($urandom));
        push_tx(PXB'($urandom));
        send_q.push_back(PXB'($urandom));
        frame(0);
        drain();

        // TX empty at frame start
        send_q.push_back(PXB'($urandom));
        frame(0);
        chk("tx_ready_empty", {31'd0, tx_ready_o}, 32'd1);
        drain();

        // CS raised after 10 bits, then a clean frame
        push_tx(PXB'($urandom));
        send_q.push_back(PXB'($urandom));
        frame(10);
        chk("abort_no_rx", {31'd0, rx_valid_o}, 32'd0);
        push_tx(PXB'($urandom));
        push_tx(PXB'($urandom));
        send_q.push_back(PXB'($urandom));
        frame(0);
        drain();

        // randomized frames, including TX pushes while full
        for (int t = 0; t < 12; t++) begin
            int np;
            int nw;
            np = $urandom_range(0, 5);
            nw = $urandom_range(1, 3);
            for (int j = 0; j < np; j++) push_tx(PXB'($urandom));
            ready_en = 1'($urandom_range(0, 1));
            tick(3);
            for (int j = 0; j < nw; j++) send_q.push_back(PXB'($urandom));
            frame(0);
            drain();
        end

        // reset mid-word with two RX entries queued
        ready_en = 1'b0;
        tick(3);
        push_tx(PXB'($urandom));
        spi_cs_i = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        model_load();
        tick(6);
        shift_word(PXB'($urandom), PXB);
        shift_word(PXB'($urandom), PXB);
        shift_word(PXB'($urandom), 5);
        tick(2);
        chk("rx_queued", {31'd0, rx_valid_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        chk("mid_rst_err", {30'd0, err_o}, 32'd0);
        chk("mid_rst_sdo", {31'd0, spi_sdo_o}, 32'd0);
        exp_rx.delete();
        exp_miso.delete();
        tx_m.delete();
        tick(3);
        reset_i = 1'b0;
        tick(8);
        chk("busy_after_reset", {31'd0, busy_o}, 32'd0);
        spi_cs_i = 1'b1;
        tick(4);
        push_tx(PXB'($urandom));
        push_tx(PXB'($urandom));
        send_q.push_back(PXB'($urandom));
        frame(0);
        drain();

        chk("miso_all_seen", exp_miso.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
